fetch_module: RTL and testbench
===============================

# fetch_module

Instruction fetch front end for the Tomasulo core. It drives a fixed-latency instruction-memory read port and buffers returned words in a small FIFO. It then presents them to dispatch as `out_insnbits` / `out_fetch_done`, honouring dispatch's stall. Redirects from the ROB on mispredict flush the front end. Fetch stops on a halt encoding.

## Interface
Parameters:
- `PC_WIDTH`, 64: PC and address width.
- `RESET_PC`, 0: PC loaded on reset.
- `QDEPTH`, 4: fetch FIFO entries; power of two, ≥2.
- `HLT_INSN`, 32'hD4400000: encoding that halts fetch.

Ports:
- `in_clk`, in, 1: the single clock.
- `in_rst`, in, 1: reset; synchronous, active-high.
- `in_start`, in, 1: begin fetching from IDLE.
- `in_stall`, in, 1: dispatch cannot accept this cycle (dispatch `out_stalled`).
- `in_redirect`, in, 1: ROB mispredict flush.
- `in_redirect_pc`, in, PC_WIDTH: new fetch PC.
- `out_imem_req`, out, 1: read request this cycle.
- `out_imem_addr`, out, PC_WIDTH: byte address of request.
- `in_imem_data`, in, 32: read data, valid exactly 1 cycle after the request.
- `out_insnbits`, out, 32: instruction at FIFO head.
- `out_pc`, out, PC_WIDTH: PC of head instruction.
- `out_fetch_done`, out, 1: head valid (FIFO non-empty).
- `out_halted`, out, 1: FSM in HALT.

## Operation
- FSM states: IDLE, RUN, HALT.
  - IDLE→RUN on `in_start`.
  - RUN→HALT when a word equal to `HLT_INSN` is written into the FIFO.
  - HALT→RUN on `in_redirect`.
  - Any state→IDLE on `in_rst`.
- State: `pc`, an inflight bit (request issued last cycle, not squashed), and the FIFO of {pc, insn} with a count 0..QDEPTH.
- Issue rule: `out_imem_req` = state==RUN && !in_redirect && (count + inflight) < QDEPTH. Address = `pc`. On issue, `pc <= pc + 4` (modulo 2^PC_WIDTH) and inflight is set.
- Capture: if inflight was set, `in_imem_data` is pushed with its request PC. Otherwise the data is ignored.
- Pop: the head is consumed when `out_fetch_done && !in_stall`. A same-cycle push and pop leaves count unchanged.
- Credit from a pop becomes visible the following cycle. It is not visible combinationally.
- Halt: a pushed HLT word is still delivered to dispatch. Fetch issues no further requests, and any inflight request is squashed.
- Redirect has the highest priority in RUN and HALT:
  - FIFO emptied and inflight cleared.
  - Returning data dropped.
  - `pc <= in_redirect_pc`; state RUN.
  - No request is issued in the redirect cycle.
  - `in_redirect` is ignored in IDLE.
- `in_start` is ignored outside IDLE.
- Reset values:
  - `pc`=RESET_PC, count=0, inflight=0, state=IDLE.
  - `out_imem_req`=0, `out_fetch_done`=0, `out_halted`=0, `out_insnbits`=0, `out_pc`=0.
  - `out_imem_addr`=RESET_PC.

## Timing
- Cycle 0: `in_start` sampled.
- Cycle 1: request for RESET_PC.
- Cycle 2: data captured.
- Cycle 3: `out_fetch_done`=1.
- Steady-state throughput is 1 instruction/cycle with no stall.
- Under stall, the FIFO fills to exactly QDEPTH and requests stop. No word is lost, because issue counts the inflight request.
- After `in_redirect` in cycle N:
  - `out_fetch_done`=0 in cycle N+1.
  - Request to `in_redirect_pc` in cycle N+1.
  - Head valid in cycle N+3.
- Reset asserted mid-operation clears all state at that edge. Data returning the next cycle is ignored.
- `out_insnbits`/`out_pc` are don't-care when `out_fetch_done`=0. They hold stable while the head is stalled.

## Test plan
- Reset, then `in_start` with the memory returning addr-derived words (addr>>2) → `out_fetch_done` first high in cycle 3. Then one instruction per cycle with PCs 0, 4, 8, …; `out_halted`=0.
- Stall held from cycle 3 for 10 cycles → FIFO count reaches 4 and `out_imem_req` drops. Head stays PC 0 throughout. On release, PCs 0, 4, 8, 12, 16 are delivered with no gap or duplicate.
- Redirect to 0x100 while the FIFO holds 3 entries and a request is inflight → next cycle `out_fetch_done`=0 and the request address is 0x100. The inflight word is dropped, and the next delivered PC is 0x100.
- Memory returns HLT_INSN at 0x8 → the instruction at 0x8 is delivered. `out_halted`=1, no request after the HLT capture, and the 0xC data is never delivered. A redirect to 0x40 then resumes at 0x40.
- `in_rst` pulsed mid-stream with 2 entries queued → all outputs at reset values next cycle. No fetch until `in_start` is asserted again.
- PC_WIDTH=8, redirect to 0xFC → PCs 0xFC, 0x00, 0x04 (wrap-around).

Source files
------------

// File: rtl/fetch_module.sv
// fetch_module: instruction fetch front end with a fixed-latency imem port and a small {pc, insn} FIFO.
module fetch_module #(
  parameter int PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int QDEPTH = 4,
  parameter logic [31:0] HLT_INSN = 32'hD4400000
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_start,
  input  logic                in_stall,
  input  logic                in_redirect,
  input  logic [PC_WIDTH-1:0] in_redirect_pc,
  output logic                out_imem_req,
  output logic [PC_WIDTH-1:0] out_imem_addr,
  input  logic [31:0]         in_imem_data,
  output logic [31:0]         out_insnbits,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_fetch_done,
  output logic                out_halted
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
  state_e state_q;
  logic [PC_WIDTH-1:0] pc_q, req_pc_q;
  logic infl_q;
  logic [AW:0] cnt_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [31:0] insn_q [QDEPTH];
  logic [PC_WIDTH-1:0] ipc_q [QDEPTH];
  logic redir, push, pop, hlt_push;
  assign redir = in_redirect && state_q != IDLE;
  assign push = infl_q && !redir;
  assign pop = cnt_q != '0 && !in_stall;
  assign hlt_push = push && in_imem_data == HLT_INSN;
  // the inflight request holds a slot so a stalled FIFO can never overflow
  assign out_imem_req = state_q == RUN && !in_redirect && (cnt_q + (AW+1)'(infl_q)) < FULL;
  assign out_imem_addr = pc_q;
  assign out_fetch_done = cnt_q != '0;
  assign out_insnbits = out_fetch_done ? insn_q[rd_q] : '0;
  assign out_pc = out_fetch_done ? ipc_q[rd_q] : '0;
  assign out_halted = state_q == HALT;
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      req_pc_q <= RESET_PC;
      infl_q <= 1'b0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else if (redir) begin
      state_q <= RUN;
      pc_q <= in_redirect_pc;
      infl_q <= 1'b0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (state_q == IDLE && in_start) state_q <= RUN;
      if (hlt_push) state_q <= HALT;
      if (out_imem_req) begin
        pc_q <= pc_q + PC_WIDTH'(4);
        req_pc_q <= pc_q;
      end
      // a request issued alongside the halt word is squashed
      infl_q <= out_imem_req && !hlt_push;
      if (push) begin
        insn_q[wr_q] <= in_imem_data;
        ipc_q[wr_q] <= req_pc_q;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_module.sv
// tb_fetch_module: directed vectors for fetch_module, plus an 8-bit PC instance for wrap-around.
module tb_fetch_module;
  localparam logic [31:0] HLT = 32'hD4400000;
  logic clk = 0, rst = 0, start = 0, stall = 0, redirect = 0;
  logic [63:0] rpc = 0;
  logic req, done, halted;
  logic [63:0] addr, opc;
  logic [31:0] data = 0, insn;
  logic start8 = 0, redir8 = 0, stall8 = 0;
  logic [7:0] rpc8 = 0, addr8, pc8;
  logic req8, done8, halted8;
  logic [31:0] data8 = 0, insn8;
  logic halt_en = 0;
  logic [63:0] halt_addr = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fetch_module dut (
    .in_clk(clk), .in_rst(rst), .in_start(start), .in_stall(stall),
    .in_redirect(redirect), .in_redirect_pc(rpc), .out_imem_req(req),
    .out_imem_addr(addr), .in_imem_data(data), .out_insnbits(insn),
    .out_pc(opc), .out_fetch_done(done), .out_halted(halted)
  );
  fetch_module #(.PC_WIDTH(8)) dut8 (
    .in_clk(clk), .in_rst(rst), .in_start(start8), .in_stall(stall8),
    .in_redirect(redir8), .in_redirect_pc(rpc8), .out_imem_req(req8),
    .out_imem_addr(addr8), .in_imem_data(data8), .out_insnbits(insn8),
    .out_pc(pc8), .out_fetch_done(done8), .out_halted(halted8)
  );

  // one-cycle memory: words are addr>>2 unless the halt address is armed
  always @(posedge clk) begin
    data <= !req ? 32'hFFFF_FFFF : (halt_en && addr == halt_addr) ? HLT : 32'(addr >> 2);
    data8 <= req8 ? 32'(addr8 >> 2) : 32'hFFFF_FFFF;
  end

  typedef struct {
    logic start, stall, req;
    logic [63:0] addr;
    logic done;
    logic [63:0] pc;
    logic halted;
  } vec_t;
  vec_t vec [7];

  task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic outs(input int c, input logic e_req, input logic [63:0] e_addr, input logic e_done,
                      input logic [63:0] e_pc, input logic e_halt);
    chk("req", c, 64'(req), 64'(e_req));
    if (e_req) chk("addr", c, addr, e_addr);
    chk("done", c, 64'(done), 64'(e_done));
    if (e_done) begin
      chk("pc", c, opc, e_pc);
      chk("insn", c, 64'(insn), (e_halt && e_pc == halt_addr) ? 64'(HLT) : (e_pc >> 2));
    end
    chk("halted", c, 64'(halted), 64'(e_halt));
  endtask

  task automatic cyc(input logic st, input logic sl, input logic rd, input logic [63:0] p);
    @(posedge clk);
    #1;
    start = st; stall = sl; redirect = rd; rpc = p;
    #1;
  endtask

  task automatic reset_values(input string name);
    chk({name, "_req"}, 0, 64'(req), 0);
    chk({name, "_done"}, 0, 64'(done), 0);
    chk({name, "_halted"}, 0, 64'(halted), 0);
    chk({name, "_insn"}, 0, 64'(insn), 0);
    chk({name, "_pc"}, 0, opc, 0);
    chk({name, "_addr"}, 0, addr, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1; start = 0; stall = 0; redirect = 0; start8 = 0; redir8 = 0;
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    reset_values("rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = '{1, 0, 0, 0, 0, 0, 0};
    vec[1] = '{0, 0, 1, 0, 0, 0, 0};
    vec[2] = '{0, 0, 1, 4, 0, 0, 0};
    vec[3] = '{0, 0, 1, 8, 1, 0, 0};
    vec[4] = '{0, 0, 1, 12, 1, 4, 0};
    vec[5] = '{0, 0, 1, 16, 1, 8, 0};
    vec[6] = '{0, 0, 1, 20, 1, 12, 0};

    // startup latency and steady stream
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(vec[i].start, vec[i].stall, 0, 0);
      outs(i, vec[i].req, vec[i].addr, vec[i].done, vec[i].pc, vec[i].halted);
    end

    // stall from cycle 3 for 10 cycles, then release
    do_reset();
    for (int c = 0; c < 18; c++) begin
      cyc(c == 0, c >= 3 && c <= 12, 0, 0);
      if (c == 4) chk("stall_req_c4", c, 64'(req), 1);
      if (c >= 5 && c <= 12) chk("stall_req_off", c, 64'(req), 0);
      if (c >= 3 && c <= 12) begin
        chk("stall_done", c, 64'(done), 1);
        chk("stall_head", c, opc, 0);
      end
      if (c >= 13) begin
        chk("release_done", c, 64'(done), 1);
        chk("release_pc", c, opc, 64'((c - 13) * 4));
        chk("release_insn", c, 64'(insn), 64'(c - 13));
      end
    end

    // redirect with 3 queued entries and one inflight
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc(c == 0, c >= 3 && c <= 5, c == 5, 64'h100);
      if (c == 5) outs(c, 0, 0, 1, 0, 0);
      if (c == 6) outs(c, 1, 64'h100, 0, 0, 0);
      if (c == 7) outs(c, 1, 64'h104, 0, 0, 0);
      if (c == 8) outs(c, 1, 64'h108, 1, 64'h100, 0);
      if (c == 9) outs(c, 1, 64'h10C, 1, 64'h104, 0);
    end

    // halt word at 0x8, then redirect to 0x40
    halt_en = 1; halt_addr = 64'h8;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      cyc(c == 0, 0, c == 9, 64'h40);
      if (c == 4) outs(c, 1, 12, 1, 4, 0);
      if (c == 5) outs(c, 0, 0, 1, 8, 1);
      if (c >= 6 && c <= 9) outs(c, 0, 0, 0, 0, 1);
      if (c == 10) outs(c, 1, 64'h40, 0, 0, 0);
      if (c == 12) outs(c, 1, 64'h48, 1, 64'h40, 0);
    end
    halt_en = 0;

    // reset mid-stream with 2 entries queued
    do_reset();
    for (int c = 0; c < 13; c++) begin
      cyc(c == 0 || c == 9, c >= 3 && c <= 4, 0, 0);
      rst = (c == 4);
      if (c == 4) chk("pre_rst_done", c, 64'(done), 1);
      if (c == 5) reset_values("midrst");
      if (c >= 6 && c <= 9) outs(c, 0, 0, 0, 0, 0);
      if (c == 10) outs(c, 1, 0, 0, 0, 0);
      if (c == 12) outs(c, 1, 8, 1, 0, 0);
    end

    // 8-bit PC wrap-around
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      start8 = (c == 0); redir8 = (c == 2); rpc8 = 8'hFC;
      #1;
      if (c == 3) begin
        chk("w_req", c, 64'(req8), 1);
        chk("w_addr", c, 64'(addr8), 64'hFC);
        chk("w_done", c, 64'(done8), 0);
      end
      if (c == 4) chk("w_addr_wrap", c, 64'(addr8), 0);
      if (c >= 5) begin
        chk("w_done_on", c, 64'(done8), 1);
        chk("w_pc", c, 64'(pc8), 64'(8'(8'hFC + 8'((c - 5) * 4))));
        chk("w_insn", c, 64'(insn8), 64'(8'(8'hFC + 8'((c - 5) * 4)) >> 2));
        chk("w_halted", c, 64'(halted8), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
